// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl: filtered line-tracker steering FSM with search and
// obstacle recovery, driving per-wheel PWM whose duty latches at wrap.
module line_follow_ctrl #(
    parameter int SENSORS      = 3,
    parameter int FILT         = 1000,
    parameter int LOST_TIMEOUT = 50_000_000,
    parameter int CLEAR_CYC    = 10_000_000,
    parameter int PWM_W        = 10,
    parameter int FWD_DUTY     = 700,
    parameter int TURN_DUTY    = 600,
    parameter int SPIN_DUTY    = 450
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [SENSORS-1:0] sensor,
    input  logic               stop,
    output logic [1:0]         left,
    output logic [1:0]         right,
    output logic               left_motor,
    output logic               right_motor,
    output logic [2:0]         state,
    output logic [3:0]         LED
);
    localparam int C  = (SENSORS - 1) / 2;
    localparam int FW = $clog2(FILT + 1);
    localparam int SW = $clog2(LOST_TIMEOUT + 1);
    localparam int CW = $clog2(CLEAR_CYC + 1);
    localparam logic [PWM_W-1:0] PMAX = '1;

    function automatic logic [PWM_W-1:0] sat(input int d);
        if (d >= (1 << PWM_W)) return PMAX;
        return PWM_W'(d);
    endfunction

    localparam logic [PWM_W-1:0] D_FWD  = sat(FWD_DUTY);
    localparam logic [PWM_W-1:0] D_TURN = sat(TURN_DUTY);
    localparam logic [PWM_W-1:0] D_SPIN = sat(SPIN_DUTY);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FWD     = 3'd1,
        S_LEFT    = 3'd2,
        S_RIGHT   = 3'd3,
        S_SEARCH  = 3'd4,
        S_BLOCKED = 3'd5,
        S_GIVEUP  = 3'd6
    } state_t;

    logic [SENSORS-1:0] sen_s1, sen_s2, filt;
    logic               stop_s1, stop_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sen_s1  <= '0;
            sen_s2  <= '0;
            stop_s1 <= 1'b0;
            stop_s2 <= 1'b0;
        end else begin
            sen_s1  <= sensor;
            sen_s2  <= sen_s1;
            stop_s1 <= stop;
            stop_s2 <= stop_s1;
        end
    end

    for (genvar i = 0; i < SENSORS; i++) begin : g_filt
        logic [FW-1:0] cnt;
        logic          f;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                f   <= 1'b0;
            end else if (sen_s2[i] == f) begin
                cnt <= '0;
            end else if (cnt == FW'(FILT - 1)) begin
                cnt <= '0;
                f   <= sen_s2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign filt[i] = f;
    end

    logic   lft, rgt, any;
    state_t tgt;

    assign lft = |filt[SENSORS-1:C+1];
    assign rgt = |filt[C-1:0];
    assign any = |filt;

    // Decoded steering target; SEARCH stands for "line lost".
    always_comb begin
        tgt = S_FWD;
        if (lft && !rgt)      tgt = S_LEFT;
        else if (rgt && !lft) tgt = S_RIGHT;
        else if (!any)        tgt = S_SEARCH;
    end

    state_t        st;
    logic [SW-1:0] scnt;
    logic [CW-1:0] ccnt;
    logic          last_r;
    logic          steer;

    assign steer = (st == S_FWD) || (st == S_LEFT) || (st == S_RIGHT)
                   || (st == S_SEARCH && any);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= S_IDLE;
            scnt   <= '0;
            ccnt   <= '0;
            last_r <= 1'b0;
        end else if (!enable) begin
            st <= S_IDLE;
        end else if (stop_s2 && st != S_IDLE) begin
            st   <= S_BLOCKED;
            ccnt <= '0;
        end else begin
            if (steer && (tgt == S_LEFT || tgt == S_RIGHT))
                last_r <= (tgt == S_RIGHT);
            unique case (st)
                S_IDLE: st <= S_FWD;
                S_FWD, S_LEFT, S_RIGHT: begin
                    st <= tgt;
                    if (tgt == S_SEARCH) scnt <= '0;
                end
                S_SEARCH: begin
                    if (any)
                        st <= tgt;
                    else if (scnt == SW'(LOST_TIMEOUT - 1))
                        st <= S_GIVEUP;
                    else
                        scnt <= scnt + 1'b1;
                end
                S_BLOCKED: begin
                    if (ccnt == CW'(CLEAR_CYC - 1))
                        st <= S_FWD;
                    else
                        ccnt <= ccnt + 1'b1;
                end
                S_GIVEUP: st <= S_GIVEUP;
                default:  st <= S_IDLE;
            endcase
        end
    end

    assign state = st;

    logic [PWM_W-1:0] duty_tgt, duty_act, pcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left     <= 2'b00;
            right    <= 2'b00;
            LED      <= 4'b0000;
            duty_tgt <= '0;
        end else begin
            unique case (st)
                S_FWD: begin
                    left <= 2'b10; right <= 2'b10;
                    LED <= 4'b0001; duty_tgt <= D_FWD;
                end
                S_LEFT: begin
                    left <= 2'b01; right <= 2'b10;
                    LED <= 4'b0100; duty_tgt <= D_TURN;
                end
                S_RIGHT: begin
                    left <= 2'b10; right <= 2'b01;
                    LED <= 4'b0010; duty_tgt <= D_TURN;
                end
                S_SEARCH: begin
                    left  <= last_r ? 2'b10 : 2'b01;
                    right <= last_r ? 2'b01 : 2'b10;
                    LED <= 4'b0110; duty_tgt <= D_SPIN;
                end
                S_BLOCKED: begin
                    left <= 2'b00; right <= 2'b00;
                    LED <= 4'b1000; duty_tgt <= '0;
                end
                S_GIVEUP: begin
                    left <= 2'b00; right <= 2'b00;
                    LED <= 4'b1111; duty_tgt <= '0;
                end
                default: begin
                    left <= 2'b00; right <= 2'b00;
                    LED <= 4'b0000; duty_tgt <= '0;
                end
            endcase
        end
    end

    // Duty only moves at the wrap so no period is ever truncated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt     <= '0;
            duty_act <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
            if (pcnt == PMAX) duty_act <= duty_tgt;
        end
    end

    assign left_motor  = (pcnt < duty_act);
    assign right_motor = (pcnt < duty_act);
endmodule

// File: tb/tb_line_follow_ctrl.sv
// Scoreboard bench for line_follow_ctrl: directed stimulus pushes timed
// expected output tuples; a negedge monitor pops them on every change.
module tb_line_follow_ctrl;
    localparam int FILT = 4;
    localparam int LAT  = 2 + FILT + 1;

    logic       clk, rst, enable, stop;
    logic [2:0] sensor;
    logic [1:0] left, right;
    logic       left_motor, right_motor;
    logic [2:0] state;
    logic [3:0] LED;

    line_follow_ctrl #(
        .SENSORS(3), .FILT(FILT), .LOST_TIMEOUT(50), .CLEAR_CYC(8),
        .PWM_W(4), .FWD_DUTY(12), .TURN_DUTY(8), .SPIN_DUTY(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .sensor(sensor),
        .stop(stop), .left(left), .right(right),
        .left_motor(left_motor), .right_motor(right_motor),
        .state(state), .LED(LED)
    );

    typedef struct {
        int          cyc;
        logic [10:0] obs;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_cur;
    logic [10:0] obs;
    logic [10:0] prev = '0;
    logic        mon_en = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    assign obs = {state, left, right, LED};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        n_chk++;
        if (act !== want)
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, want, cyc);
        else
            n_pass++;
    endtask

    task automatic push(int c, logic [2:0] s, logic [3:0] lr, logic [3:0] led);
        exp_t e;
        e.cyc = c;
        e.obs = {s, lr, led};
        sb.push_back(e);
    endtask

    task automatic tick_to(int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pwm_check(string nm, int start, int d);
        logic [15:0] pl, pr, ex;
        tick_to(start);
        for (int i = 0; i < 16; i++) begin
            pl[i] = left_motor;
            pr[i] = right_motor;
            ex[i] = (i < d);
            if (i < 15) @(negedge clk);
        end
        chk({nm, "_l"}, {16'h0, pl}, {16'h0, ex});
        chk({nm, "_r"}, {16'h0, pr}, {16'h0, ex});
    endtask

    always @(negedge clk) begin
        if (mon_en && obs !== prev) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_change: got %0h at cyc %0d, want none",
                         obs, cyc);
            end else begin
                e_cur = sb.pop_front();
                chk("obs", {21'h0, obs}, {21'h0, e_cur.obs});
                chk("obs_cyc", cyc, e_cur.cyc);
            end
            prev = obs;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        rst = 1'b1; enable = 1'b0; sensor = 3'b010; stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_obs", {21'h0, obs}, 32'h0);
        chk("rst_pwm", {30'h0, left_motor, right_motor}, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;

        tick_to(10);
        t = cyc; enable = 1'b1;
        push(t + 1, 3'd1, 4'b0000, 4'b0000);
        push(t + 2, 3'd1, 4'b1010, 4'b0001);
        pwm_check("pwm_fwd", 16, 12);

        sensor = 3'b100;
        tick_to(34);
        sensor = 3'b010;

        fork
            pwm_check("latch_old", 48, 12);
            begin
                tick_to(50);
                t = cyc; sensor = 3'b100;
                push(t + LAT,     3'd2, 4'b1010, 4'b0001);
                push(t + LAT + 1, 3'd2, 4'b0110, 4'b0100);
            end
        join
        pwm_check("latch_new", 64, 8);

        t = cyc; sensor = 3'b000;
        push(t + LAT,      3'd4, 4'b0110, 4'b0100);
        push(t + LAT + 1,  3'd4, 4'b0110, 4'b0110);
        push(t + LAT + 50, 3'd6, 4'b0110, 4'b0110);
        push(t + LAT + 51, 3'd6, 4'b0000, 4'b1111);
        pwm_check("pwm_spin", 96, 4);
        pwm_check("pwm_giveup", 144, 0);

        t = cyc; enable = 1'b0; sensor = 3'b001;
        push(t + 1, 3'd0, 4'b0000, 4'b1111);
        push(t + 2, 3'd0, 4'b0000, 4'b0000);

        tick_to(170);
        t = cyc; enable = 1'b1;
        push(t + 1, 3'd1, 4'b0000, 4'b0000);
        push(t + 2, 3'd3, 4'b1010, 4'b0001);
        push(t + 3, 3'd3, 4'b1001, 4'b0010);

        tick_to(180);
        t = cyc; sensor = 3'b000;
        push(t + LAT,     3'd4, 4'b1001, 4'b0010);
        push(t + LAT + 1, 3'd4, 4'b1001, 4'b0110);

        tick_to(200);
        t = cyc; sensor = 3'b001;
        push(t + LAT,     3'd3, 4'b1001, 4'b0110);
        push(t + LAT + 1, 3'd3, 4'b1001, 4'b0010);

        tick_to(210);
        t = cyc; sensor = 3'b010;
        push(t + LAT,     3'd1, 4'b1001, 4'b0010);
        push(t + LAT + 1, 3'd1, 4'b1010, 4'b0001);

        tick_to(225);
        t = cyc; stop = 1'b1;
        push(t + 3, 3'd5, 4'b1010, 4'b0001);
        push(t + 4, 3'd5, 4'b0000, 4'b1000);
        @(negedge clk); stop = 1'b0;

        tick_to(231);
        t = cyc; stop = 1'b1;
        push(t + 11, 3'd1, 4'b0000, 4'b1000);
        push(t + 12, 3'd1, 4'b1010, 4'b0001);
        @(negedge clk); stop = 1'b0;

        tick_to(258);
        chk("pwm_pre_rst", {30'h0, left_motor, right_motor}, 32'h3);
        chk("sb_drained", sb.size(), 0);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_pwm", {30'h0, left_motor, right_motor}, 32'h0);
        chk("rst_async_obs", {21'h0, obs}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
